rv_decode_stage: RTL
====================

Name: rv_decode_stage

Overview:
- Registered RV32I decode stage: accepts raw 32-bit instructions plus PC from fetch over a valid/ready handshake.
- Produces the operand-class flags, func3/func7/shamt, register indices and sign-extended immediate that the execute-side ALU consumes.
- Single output register slot with backpressure and flush.
- Sits between instruction fetch and register-read/execute.

Parameters:
- XLEN, 32, datapath width of PC and immediate (only 32 supported).
- RESET_PC, 32'h0000_0000, value driven on pc_out after reset.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard held and incoming instruction (branch redirect)
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage can accept this cycle
- instr_in  in  32  raw instruction word
- pc_in  in  XLEN  PC of instr_in
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- pc_out  out  XLEN  registered PC
- rs1, rs2, rd  out  5 each  register indices (instr[19:15], [24:20], [11:7])
- func3  out  3  instr[14:12]
- func7  out  7  instr[31:25]
- shamt  out  5  instr[24:20]
- imm  out  32  sign-extended immediate per format
- isALUreg, isALUimm, isBranch, isJALR, isJAL, isAUIPC, isLUI, isLoad, isStore  out  1 each  one-hot instruction class
- illegal  out  1  see Optional Feature

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0; all flags=0; imm, func3, func7, shamt, rs1, rs2, rd = 0; pc_out=RESET_PC; illegal=0.
  - rst overrides flush and handshakes.
- in_ready = !out_valid || out_ready (combinational). No combinational path from instr_in to outputs.
- Accept occurs when in_valid && in_ready && !flush.
  - The bundle is registered at that edge; out_valid=1 the next cycle. Latency is 1 cycle.
- Back-to-back accepts at full throughput when out_ready stays 1. A new accept while the old bundle is consumed in the same cycle replaces it with no bubble.
- Stall (out_valid && !out_ready): every output holds bit-stable; in_ready=0.
- out_valid && out_ready with no accept: out_valid falls to 0. Data outputs hold their last values (don't-care).
- flush=1 at an edge: out_valid=0 and any incoming instruction is dropped. Flush wins over a simultaneous accept.
- Opcode map (instr[6:0]); exactly one flag set, or none:
  - 0110011 isALUreg; 0010011 isALUimm; 1100011 isBranch; 1100111 isJALR; 1101111 isJAL
  - 0010111 isAUIPC; 0110111 isLUI; 0000011 isLoad; 0100011 isStore
  - any other opcode: all flags 0.
- Immediate formats, all sign-extended from instr[31]:
  - I: {instr[31:20]} for ALUimm, JALR, Load.
  - S: {instr[31:25], instr[11:7]} for Store.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0} for Branch.
  - U: {instr[31:12], 12'b0} for LUI, AUIPC.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0} for JAL.
  - R-type and unknown opcodes: imm=0.
- func7 is passed raw for every format. Execute qualifies SUB with isALUreg and SRA/SRL with func7[5].

Optional Feature:
- Macro DECODE_ILLEGAL_EN.
- Defined: illegal=1 alongside out_valid when any of these holds:
  - opcode not in the map;
  - instr[1:0] != 2'b11;
  - ALUreg with func7 not in {0x00, 0x20}, or func7=0x20 with func3 not in {000, 101};
  - ALUimm shift (func3 001/101) with illegal func7;
  - Branch with func3 010/011;
  - Load func3 011/110/111; Store func3 >= 011; JALR func3 != 000.
  - When illegal=1, all class flags are forced to 0.
- Not defined: the illegal port is tied 0 and the checker logic is absent. Unknown opcodes still clear all flags.

Test Plan:
- Reset, then instr 0x002081B3 (ADD x3,x1,x2), pc 0x100 -> next cycle out_valid=1, isALUreg=1, rd=3, rs1=1, rs2=2, func7=0, imm=0, pc_out=0x100.
- 0x402081B3 (SUB) then 0x4030D093 (SRAI x1,x1,3) back-to-back, out_ready=1 -> consecutive bundles: func7=0x20 with isALUreg; then isALUimm, func3=101, func7=0x20, shamt=3.
- 0xFFF00093 (ADDI x1,x0,-1) -> imm=0xFFFFFFFF. 0x123452B7 (LUI x5) -> isLUI, imm=0x12345000, rd=5.
- 0x008000EF (JAL x1,+8) with out_ready=0 for 3 cycles -> isJAL, imm=8, outputs stable, in_ready=0; accepted once out_ready=1.
- Flush asserted on the same cycle as a valid accept while holding a bundle -> out_valid=0 next cycle; no bundle emitted.
- DECODE_ILLEGAL_EN defined, instr 0x0000007F -> out_valid=1, illegal=1, all flags 0. Undefined -> illegal=0, all flags 0.

Source files
------------

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage with a valid/ready handshake, a single output slot and flush.
// Define DECODE_ILLEGAL_EN to enable illegal-instruction detection on the illegal output.
module rv_decode_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [4:0]      shamt,
  output logic [31:0]     imm,
  output logic            isALUreg,
  output logic            isALUimm,
  output logic            isBranch,
  output logic            isJALR,
  output logic            isJAL,
  output logic            isAUIPC,
  output logic            isLUI,
  output logic            isLoad,
  output logic            isStore,
  output logic            illegal
);

  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  // Class vector bit order: {ALUreg, ALUimm, Branch, JALR, JAL, AUIPC, LUI, Load, Store}
  localparam logic [8:0] CLS_ALUREG = 9'b1_0000_0000;
  localparam logic [8:0] CLS_ALUIMM = 9'b0_1000_0000;
  localparam logic [8:0] CLS_BRANCH = 9'b0_0100_0000;
  localparam logic [8:0] CLS_JALR   = 9'b0_0010_0000;
  localparam logic [8:0] CLS_JAL    = 9'b0_0001_0000;
  localparam logic [8:0] CLS_AUIPC  = 9'b0_0000_1000;
  localparam logic [8:0] CLS_LUI    = 9'b0_0000_0100;
  localparam logic [8:0] CLS_LOAD   = 9'b0_0000_0010;
  localparam logic [8:0] CLS_STORE  = 9'b0_0000_0001;

  logic [6:0]      opcode_s;
  logic [2:0]      func3_s;
  logic [6:0]      func7_s;
  logic [31:0]     imm_i_s;
  logic [31:0]     imm_s_s;
  logic [31:0]     imm_b_s;
  logic [31:0]     imm_u_s;
  logic [31:0]     imm_j_s;
  logic [8:0]      cls_raw_s;
  logic            accept_s;

  logic            valid_d,  valid_q;
  logic [XLEN-1:0] pc_d,     pc_q;
  logic [8:0]      cls_d,    cls_q;
  logic [31:0]     imm_d,    imm_q;
  logic [4:0]      rs1_d,    rs1_q;
  logic [4:0]      rs2_d,    rs2_q;
  logic [4:0]      rd_d,     rd_q;
  logic [2:0]      func3_d,  func3_q;
  logic [6:0]      func7_d,  func7_q;
  logic [4:0]      shamt_d,  shamt_q;

  assign opcode_s = instr_in[6:0];
  assign func3_s  = instr_in[14:12];
  assign func7_s  = instr_in[31:25];

  assign imm_i_s = {{20{instr_in[31]}}, instr_in[31:20]};
  assign imm_s_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign imm_b_s = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                    instr_in[11:8], 1'b0};
  assign imm_u_s = {instr_in[31:12], 12'h000};
  assign imm_j_s = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                    instr_in[30:21], 1'b0};

  assign in_ready = !valid_q || out_ready;
  assign accept_s = in_valid && in_ready && !flush;

  // Opcode to instruction class and immediate format selection
  always_comb begin
    cls_raw_s = 9'd0;
    imm_d     = 32'd0;
    case (opcode_s)
      OP_ALUREG: begin cls_raw_s = CLS_ALUREG; imm_d = 32'd0;   end
      OP_ALUIMM: begin cls_raw_s = CLS_ALUIMM; imm_d = imm_i_s; end
      OP_BRANCH: begin cls_raw_s = CLS_BRANCH; imm_d = imm_b_s; end
      OP_JALR:   begin cls_raw_s = CLS_JALR;   imm_d = imm_i_s; end
      OP_JAL:    begin cls_raw_s = CLS_JAL;    imm_d = imm_j_s; end
      OP_AUIPC:  begin cls_raw_s = CLS_AUIPC;  imm_d = imm_u_s; end
      OP_LUI:    begin cls_raw_s = CLS_LUI;    imm_d = imm_u_s; end
      OP_LOAD:   begin cls_raw_s = CLS_LOAD;   imm_d = imm_i_s; end
      OP_STORE:  begin cls_raw_s = CLS_STORE;  imm_d = imm_s_s; end
      default:   begin cls_raw_s = 9'd0;       imm_d = 32'd0;   end
    endcase
  end

`ifdef DECODE_ILLEGAL_EN
  logic illegal_d, illegal_q;

  // Encoding legality check; an illegal word carries no class so execute ignores it
  always_comb begin
    illegal_d = 1'b0;
    case (opcode_s)
      OP_ALUREG: illegal_d = !((func7_s == 7'h00) ||
                               ((func7_s == 7'h20) && ((func3_s == 3'b000) || (func3_s == 3'b101))));
      OP_ALUIMM: begin
        if (func3_s == 3'b001) begin
          illegal_d = (func7_s != 7'h00);
        end else if (func3_s == 3'b101) begin
          illegal_d = (func7_s != 7'h00) && (func7_s != 7'h20);
        end else begin
          illegal_d = 1'b0;
        end
      end
      OP_BRANCH: illegal_d = (func3_s == 3'b010) || (func3_s == 3'b011);
      OP_LOAD:   illegal_d = (func3_s == 3'b011) || (func3_s == 3'b110) || (func3_s == 3'b111);
      OP_STORE:  illegal_d = (func3_s >= 3'b011);
      OP_JALR:   illegal_d = (func3_s != 3'b000);
      OP_JAL:    illegal_d = 1'b0;
      OP_AUIPC:  illegal_d = 1'b0;
      OP_LUI:    illegal_d = 1'b0;
      default:   illegal_d = 1'b1;
    endcase
    if (instr_in[1:0] != 2'b11) begin
      illegal_d = 1'b1;
    end else begin
      illegal_d = illegal_d;
    end
  end

  assign cls_d = illegal_d ? 9'd0 : cls_raw_s;

  // Illegal flag register, loaded together with the bundle
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (accept_s) begin
      illegal_q <= illegal_d;
    end else begin
      illegal_q <= illegal_q;
    end
  end

  assign illegal = illegal_q;
`else
  assign cls_d   = cls_raw_s;
  assign illegal = 1'b0;
`endif

  assign pc_d    = pc_in;
  assign rs1_d   = instr_in[19:15];
  assign rs2_d   = instr_in[24:20];
  assign rd_d    = instr_in[11:7];
  assign func3_d = func3_s;
  assign func7_d = func7_s;
  assign shamt_d = instr_in[24:20];

  // Slot occupancy: flush empties the slot, an accept fills it, a consume drains it
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Bundle registers; they only change on an accept so a stalled bundle is bit-stable
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      cls_q   <= 9'd0;
      imm_q   <= 32'd0;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      rd_q    <= 5'd0;
      func3_q <= 3'd0;
      func7_q <= 7'd0;
      shamt_q <= 5'd0;
    end else if (accept_s) begin
      pc_q    <= pc_d;
      cls_q   <= cls_d;
      imm_q   <= imm_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      func3_q <= func3_d;
      func7_q <= func7_d;
      shamt_q <= shamt_d;
    end else begin
      pc_q    <= pc_q;
      cls_q   <= cls_q;
      imm_q   <= imm_q;
      rs1_q   <= rs1_q;
      rs2_q   <= rs2_q;
      rd_q    <= rd_q;
      func3_q <= func3_q;
      func7_q <= func7_q;
      shamt_q <= shamt_q;
    end
  end

  assign out_valid = valid_q;
  assign pc_out    = pc_q;
  assign imm       = imm_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;
  assign func3     = func3_q;
  assign func7     = func7_q;
  assign shamt     = shamt_q;
  assign {isALUreg, isALUimm, isBranch, isJALR, isJAL, isAUIPC, isLUI, isLoad, isStore} = cls_q;

endmodule
